// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for rr_mux_arbiter.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Returns {found, index} of the first set req bit searching upward from last+1.
    // Offset 4 wraps to last itself, so the current owner is the lowest-priority candidate.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux_4x1.sv
// Single-bit 4:1 mux cell; {s0,s1} selects a..d.
module mux_4x1 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic s0,
    input  logic s1,
    output logic y
);

    always_comb begin
        case ({s0, s1})
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux datapath with bounded hold time.
// Optional RR_MUX_ARB_PARK_EN: park the mux select on index 0 while idle.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  d0,
    input  logic [DATA_W-1:0]  d1,
    input  logic [DATA_W-1:0]  d2,
    input  logic [DATA_W-1:0]  d3,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s0,
    output logic               s1,
    output logic [DATA_W-1:0]  y,
    output logic               valid
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         sel_q, sel_d;

    logic [2:0] pick;
    logic       own_req;
    logic       expire;
    logic       grant_new;

    // last_q always equals the current owner while BUSY
    assign pick    = rr_pick(req, last_q);
    assign own_req = req[last_q];
    assign expire  = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick[2]) state_d = ST_BUSY;
            ST_BUSY: if (!own_req && !pick[2]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        sel_d  = sel_q;
        grant_new = pick[2] && ((state_q == ST_IDLE) || !own_req || expire);
        if (grant_new) begin
            gnt_d  = NUM_REQ'(1) << pick[1:0];
            cnt_d  = '0;
            last_d = pick[1:0];
            sel_d  = pick[1:0];
        end else if (state_d == ST_IDLE) begin
            gnt_d = '0;
            cnt_d = '0;
`ifdef RR_MUX_ARB_PARK_EN
            sel_d = 2'd0;
`else
            sel_d = sel_q;
`endif
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign gnt   = gnt_q;
    assign valid = (state_q == ST_BUSY);
    assign s0    = sel_q[1];
    assign s1    = sel_q[0];

    for (genvar k = 0; k < DATA_W; k++) begin : g_mux
        mux_4x1 u_mux (
            .a  (d0[k]),
            .b  (d1[k]),
            .c  (d2[k]),
            .d  (d3[k]),
            .s0 (s0),
            .s1 (s1),
            .y  (y[k])
        );
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (DATA_W=1, MAX_HOLD=4).
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [0:0] d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
    logic [3:0] gnt;
    logic       s0, s1, valid;
    logic [0:0] y;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.DATA_W(1), .MAX_HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt), .s0(s0), .s1(s1), .y(y), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        d0 = 1'b1; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        step();
        step();
        total++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || {s0, s1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: gnt=%b valid=%b sel=%b need gnt=0000 valid=0 sel=00", gnt, valid, {s0, s1});
        end
        rst = 1'b0;
        step();
        total++;
        if (gnt !== 4'b0001 || valid !== 1'b1 || {s0, s1} !== 2'b00 || y !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: gnt=%b valid=%b sel=%b y=%b need 0001 1 00 1", gnt, valid, {s0, s1}, y);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_g [9];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                  4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if (gnt !== exp_g[i] || valid !== 1'b1) begin
                bad++;
                $display("FAIL rotate[%0d]: gnt=%b valid=%b need gnt=%b valid=1", i, gnt, valid, exp_g[i]);
            end
        end
    endtask

    task automatic test_solo();
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (gnt !== 4'b0100 || valid !== 1'b1 || {s0, s1} !== 2'b10) begin
                bad++;
                $display("FAIL solo[%0d]: gnt=%b valid=%b sel=%b need 0100 1 10", i, gnt, valid, {s0, s1});
            end
        end
        req = 4'b0000;
        step();
        total++;
        if (gnt !== 4'b0000 || valid !== 1'b0) begin
            bad++;
            $display("FAIL solo_drop: gnt=%b valid=%b need 0000 0", gnt, valid);
        end
    endtask

    task automatic test_handoff();
        do_reset();
        d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b1;
        req = 4'b0010;
        step();
        total++;
        if (gnt !== 4'b0010 || {s0, s1} !== 2'b01 || y !== 1'b0) begin
            bad++;
            $display("FAIL handoff_own1: gnt=%b sel=%b y=%b need 0010 01 0", gnt, {s0, s1}, y);
        end
        req = 4'b1010;
        step();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL handoff_hold: gnt=%b need 0010", gnt);
        end
        req = 4'b1000;
        step();
        total++;
        if (gnt !== 4'b1000 || valid !== 1'b1 || s0 !== 1'b1 || s1 !== 1'b1 || y !== 1'b1) begin
            bad++;
            $display("FAIL handoff_zero_bubble: gnt=%b valid=%b s0=%b s1=%b y=%b need 1000 1 1 1 1",
                     gnt, valid, s0, s1, y);
        end
        req = 4'b0000;
        step();
        total++;
`ifdef RR_MUX_ARB_PARK_EN
        if (gnt !== 4'b0000 || valid !== 1'b0 || {s0, s1} !== 2'b00 || y !== 1'b0) begin
            bad++;
            $display("FAIL idle_sel: gnt=%b valid=%b sel=%b y=%b need 0000 0 00 0", gnt, valid, {s0, s1}, y);
        end
`else
        if (gnt !== 4'b0000 || valid !== 1'b0 || {s0, s1} !== 2'b11 || y !== 1'b1) begin
            bad++;
            $display("FAIL idle_sel: gnt=%b valid=%b sel=%b y=%b need 0000 0 11 1", gnt, valid, {s0, s1}, y);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_g [6];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        do_reset();
        req = 4'b0100;
        step();
        step();
        step();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL pre_reset_owner: gnt=%b need 0100", gnt);
        end
        rst = 1'b1;
        req = 4'b1111;
        step();
        total++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || {s0, s1} !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset: gnt=%b valid=%b sel=%b need 0000 0 00", gnt, valid, {s0, s1});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (gnt !== exp_g[i]) begin
                bad++;
                $display("FAIL post_reset[%0d]: gnt=%b need %b", i, gnt, exp_g[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_o [5];
        exp_o = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            step();
            total++;
            if (gnt !== exp_o[i / 4] || valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d]: gnt=%b valid=%b need %b 1", i, gnt, valid, exp_o[i / 4]);
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_solo();
        test_handoff();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
